cipher_scheduler: RTL

Round-robin scheduler that shares one iterative AES round engine between two requesters, the encrypt driver (port 0) and the decrypt driver (port 1). It accepts a block, a key and a key-length byte from the winning requester, decodes Nk/Nr, and sequences the round engine one round per clock. It then returns the 128-bit result to the owner over a valid/ready handshake. It sits between the SPI-fed drivers and a single `round_engine`, which replaces the three fully unrolled per-key-size cipher instances.

---
 rtl/aes_pkg.sv | 42 ++++
 rtl/cipher_scheduler.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, key-length decode and scheduler state encoding.
package aes_pkg;

  localparam logic [7:0] Klen128 = 8'd16;
  localparam logic [7:0] Klen192 = 8'd24;
  localparam logic [7:0] Klen256 = 8'd32;

  localparam logic [1:0] Nk128 = 2'd0;
  localparam logic [1:0] Nk192 = 2'd1;
  localparam logic [1:0] Nk256 = 2'd2;

  localparam logic [3:0] Nr128 = 4'd10;
  localparam logic [3:0] Nr192 = 4'd12;
  localparam logic [3:0] Nr256 = 4'd14;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRound,
    StFinal,
    StResp
  } sched_state_e;

  typedef struct packed {
    logic       illegal;
    logic [1:0] nk;
    logic [3:0] nr;
  } klen_dec_t;

  function automatic klen_dec_t klen_to_nr(input logic [7:0] klen);
    klen_dec_t dec;
    dec = '{illegal: 1'b0, nk: Nk128, nr: Nr128};
    case (klen)
      Klen128: dec = '{illegal: 1'b0, nk: Nk128, nr: Nr128};
      Klen192: dec = '{illegal: 1'b0, nk: Nk192, nr: Nr192};
      Klen256: dec = '{illegal: 1'b0, nk: Nk256, nr: Nr256};
      default: dec = '{illegal: 1'b1, nk: Nk128, nr: Nr128};
    endcase
    return dec;
  endfunction

endpackage

// File: rtl/cipher_scheduler.sv
// Round-robin scheduler sharing one iterative AES round engine between the
// encrypt (port 0) and decrypt (port 1) drivers.
module cipher_scheduler
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   req_valid,
  output logic [1:0]   req_ready,
  input  logic [255:0] req_data,
  input  logic [511:0] req_key,
  input  logic [15:0]  req_klen,
  output logic [1:0]   rsp_valid,
  input  logic [1:0]   rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic         core_load,
  output logic [127:0] core_data,
  output logic [255:0] core_key,
  output logic [1:0]   core_nk,
  output logic         core_round_en,
  output logic [3:0]   core_round,
  output logic         core_final,
  output logic         core_dec,
  input  logic [127:0] core_result
);

  sched_state_e state_q, state_d;
  logic         owner_q, owner_d;
  logic         last_grant_q, last_grant_d;
  logic [127:0] data_q, data_d;
  logic [255:0] key_q, key_d;
  logic [1:0]   nk_q, nk_d;
  logic [3:0]   nr_q, nr_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         err_q, err_d;
  logic         cap_q, cap_d;
  logic [127:0] rsp_data_q, rsp_data_d;

  logic         win;
  logic [7:0]   win_klen;
  klen_dec_t    win_dec;

  // On a tie the port that did not win last time is granted.
  always_comb begin
    win      = (&req_valid) ? ~last_grant_q : req_valid[1];
    win_klen = win ? req_klen[15:8] : req_klen[7:0];
    win_dec  = klen_to_nr(win_klen);
  end

  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    data_d        = data_q;
    key_d         = key_q;
    nk_d          = nk_q;
    nr_d          = nr_q;
    cnt_d         = cnt_q;
    err_d         = err_q;
    cap_d         = cap_q;
    rsp_data_d    = rsp_data_q;
    req_ready     = 2'b00;
    rsp_valid     = 2'b00;
    rsp_err       = 1'b0;
    rsp_data      = '0;
    core_load     = 1'b0;
    core_round_en = 1'b0;
    core_round    = 4'd0;
    core_final    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!reset && (|req_valid)) begin
          req_ready    = win ? 2'b10 : 2'b01;
          owner_d      = win;
          last_grant_d = win;
          data_d       = win ? req_data[255:128] : req_data[127:0];
          key_d        = win ? req_key[511:256] : req_key[255:0];
          nk_d         = win_dec.nk;
          nr_d         = win_dec.nr;
          err_d        = win_dec.illegal;
          if (win_dec.illegal) begin
            // Illegal key length bypasses the engine entirely.
            rsp_data_d = '0;
            cap_d      = 1'b0;
            state_d    = StResp;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        core_load = 1'b1;
        cnt_d     = 4'd1;
        state_d   = (nr_q == 4'd1) ? StFinal : StRound;
      end
      StRound: begin
        core_round_en = 1'b1;
        core_round    = cnt_q;
        cnt_d         = cnt_q + 4'd1;
        if (cnt_q == nr_q - 4'd1) begin
          state_d = StFinal;
        end
      end
      StFinal: begin
        core_round_en = 1'b1;
        core_final    = 1'b1;
        core_round    = nr_q;
        cap_d         = 1'b1;
        state_d       = StResp;
      end
      StResp: begin
        // The engine result is only valid in the first RESP cycle; pass it
        // through then and hold the captured copy afterwards.
        rsp_valid = owner_q ? 2'b10 : 2'b01;
        rsp_err   = err_q;
        rsp_data  = cap_q ? core_result : rsp_data_q;
        if (cap_q) begin
          rsp_data_d = core_result;
        end
        cap_d = 1'b0;
        if (rsp_ready[owner_q]) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      data_q       <= '0;
      key_q        <= '0;
      nk_q         <= 2'd0;
      nr_q         <= 4'd0;
      cnt_q        <= 4'd0;
      err_q        <= 1'b0;
      cap_q        <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      data_q       <= data_d;
      key_q        <= key_d;
      nk_q         <= nk_d;
      nr_q         <= nr_d;
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      cap_q        <= cap_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign core_data = data_q;
  assign core_key  = key_q;
  assign core_nk   = nk_q;
  assign core_dec  = owner_q;

endmodule
